// File: rtl/bias_pkg.sv
// Shared bias-path constants and the loader state type.
// Used by bias_loader and bias_store, so both agree on beat and group geometry.
package bias_pkg;
   localparam int BIAS_W          = 32;
   localparam int BIASES_PER_BEAT = 4;
   localparam int BIAS_BEAT_W     = BIAS_W * BIASES_PER_BEAT;
   localparam int BEATS_PER_OG    = 2;

   typedef enum logic [1:0] {IDLE, ADDR_RST, STREAM, DONE} bias_ld_state_t;
endpackage

// File: rtl/bias_loader_if.sv
// AXI-Stream bias beat channel from the layer DMA into bias_loader.
interface bias_loader_if;
   import bias_pkg::*;

   logic [BIAS_BEAT_W-1:0] tdata;
   logic                   tvalid;
   logic                   tlast;
   logic                   tready;

   modport master (output tdata, output tvalid, output tlast, input tready);
   modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/bias_loader.sv
// bias_loader: sequences a 2-beat-per-OG bias stream into the bias_store write port.
// One wr_addr_rst pulse per load, then one registered write per accepted beat,
// so OG k lands at words 2k and 2k+1.
// Optional macro BIAS_LOADER_TLAST_CHECK_EN: flag tlast on the wrong beat in cfg_err.
module bias_loader
   import bias_pkg::*;
#(
   parameter int MAX_DEPTH  = 256,
   parameter int ADDR_WIDTH = $clog2(MAX_DEPTH),
   parameter int MAX_OGS    = MAX_DEPTH / 2
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic [ADDR_WIDTH-1:0]  cfg_num_ogs,
   bias_loader_if.slave           s_axis,
   output logic                   wr_en,
   output logic [BIAS_BEAT_W-1:0] wr_data,
   output logic                   wr_addr_rst,
   output logic                   busy,
   output logic [ADDR_WIDTH-1:0]  ogs_loaded,
   output logic                   done,
   output logic                   cfg_err
);

   localparam logic [ADDR_WIDTH-1:0] MAX_OGS_W = ADDR_WIDTH'(MAX_OGS);
   localparam logic [ADDR_WIDTH-1:0] ONE_OG    = ADDR_WIDTH'(1);
   localparam logic [ADDR_WIDTH:0]   ONE_BEAT  = (ADDR_WIDTH+1)'(1);

   bias_ld_state_t        r_state;
   logic                  r_tready;
   // Beat counter is one bit wider than the address so 2*MAX_OGS cannot wrap
   logic [ADDR_WIDTH:0]   r_beat;
   logic [ADDR_WIDTH:0]   r_last_beat;

   logic [ADDR_WIDTH-1:0] w_n;
   logic                  w_accept;
   logic                  w_last;
   logic                  w_tlast_err;

   assign w_n           = (cfg_num_ogs > MAX_OGS_W) ? MAX_OGS_W : cfg_num_ogs;
   assign w_accept      = s_axis.tvalid && r_tready;
   assign w_last        = (r_beat == r_last_beat);
   assign s_axis.tready = r_tready;

`ifdef BIAS_LOADER_TLAST_CHECK_EN
   // tlast must mark exactly the final counted beat; completion still follows the count
   assign w_tlast_err = w_accept && (s_axis.tlast != w_last);
`else
   logic w_unused_tlast;
   assign w_unused_tlast = s_axis.tlast;
   assign w_tlast_err    = 1'b0;
`endif

   // Load FSM with all outputs registered
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_tready    <= 1'b0;
         r_beat      <= '0;
         r_last_beat <= '0;
         wr_en       <= 1'b0;
         wr_data     <= '0;
         wr_addr_rst <= 1'b0;
         busy        <= 1'b0;
         ogs_loaded  <= '0;
         done        <= 1'b0;
         cfg_err     <= 1'b0;
      end else begin
         wr_en       <= 1'b0;
         wr_addr_rst <= 1'b0;
         done        <= 1'b0;
         case (r_state)
            IDLE: begin
               busy <= 1'b0;
               // done high means this is the completion cycle: a start here is dropped
               if (start && !done) begin
                  busy        <= 1'b1;
                  cfg_err     <= (cfg_num_ogs > MAX_OGS_W);
                  ogs_loaded  <= '0;
                  r_beat      <= '0;
                  r_last_beat <= (ADDR_WIDTH+1)'(int'(w_n) * BEATS_PER_OG - 1);
                  if (w_n == '0) begin
                     r_state <= DONE;
                  end else begin
                     wr_addr_rst <= 1'b1;
                     r_state     <= ADDR_RST;
                  end
               end
            end
            ADDR_RST: begin
               r_tready <= 1'b1;
               r_state  <= STREAM;
            end
            STREAM: begin
               if (w_accept) begin
                  wr_en   <= 1'b1;
                  wr_data <= s_axis.tdata;
                  r_beat  <= r_beat + ONE_BEAT;
                  // Odd beat closes an OG (two beats per OG); count it with its write
                  if (r_beat[0]) ogs_loaded <= ogs_loaded + ONE_OG;
                  if (w_tlast_err) cfg_err <= 1'b1;
                  if (w_last) begin
                     r_tready <= 1'b0;
                     r_state  <= DONE;
                  end
               end
            end
            DONE: begin
               done    <= 1'b1;
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule
